mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  MEM pipeline stage plus MEM/WB pipeline register. Consumes EX/MEM register outputs,
//  performs byte/half/word loads and stores on an internal word-addressed data memory,
//  resolves the branch decision for the IF stage, and registers write-back info for WB.
//  Sits between EX_MEM_REG and the write-back mux/register file.
// PARAMETERS
//  ADDR_W  8   word-address bits; memory holds 2**ADDR_W 32-bit words
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   asynchronous, active-high reset
//  RD_MEM           in   5   destination register
//  RegWrite_MEM     in   1   register write enable
//  MemtoReg_MEM     in   1   WB selects memory data
//  MemRead_MEM      in   1   load
//  MemWrite_MEM     in   1   store
//  Branch_MEM       in   1   branch instruction
//  Zero_MEM         in   1   ALU zero flag
//  FUNCT3_MEM       in   3   access size: 000 B,001 H,010 W,100 BU,101 HU
//  ALU_OUT_MEM      in   32  byte address / ALU result
//  PC_Branch_MEM    in   32  branch target
//  REG_DATA2_MEM_FINAL in 32 store data (forwarded)
//  PCSrc            out  1   Branch_MEM & Zero_MEM (combinational)
//  PC_Branch_OUT    out  32  = PC_Branch_MEM (combinational)
//  RD_WB            out  5   registered RD
//  RegWrite_WB      out  1   registered write enable
//  MemtoReg_WB      out  1   registered MemtoReg
//  READ_DATA_WB     out  32  registered, extended load data
//  ALU_OUT_WB       out  32  registered ALU result
//  MISALIGN_WB      out  1   registered 1-cycle misaligned-access flag
// BEHAVIOUR
//  - Reset (async, any time): all *_WB outputs -> 0 immediately; memory array NOT reset.
//  - Word index = ALU_OUT_MEM[ADDR_W+1:2]; higher address bits ignored (wrap-around).
//  - Byte lane = ALU_OUT_MEM[1:0]; little-endian. Misaligned: H with addr[0]=1,
//    W with addr[1:0]!=0. Undefined FUNCT3 codes treated as W.
//  - Store (MemWrite_MEM=1, aligned): written at rising edge; B writes lane
//    addr[1:0] with data[7:0]; H writes lanes {addr[1],0}/+1 with data[15:0];
//    W writes all 4. Untouched lanes keep their value. Misaligned store: no write.
//  - Load (MemRead_MEM=1): read word selected combinationally from array, lane
//    extracted, sign-extended (B,H) or zero-extended (BU,HU), captured into
//    READ_DATA_WB at rising edge. Latency: 1 cycle, data valid with RegWrite_WB.
//  - Misaligned load: READ_DATA_WB=0, RegWrite_WB=0 for that instruction.
//  - MISALIGN_WB=1 for exactly the cycle the misaligned instr is in WB; else 0.
//  - MemRead_MEM=0: READ_DATA_WB=0. MemRead and MemWrite both 1: store done,
//    load returns pre-store word (read before write within the edge).
//  - Store at edge N then load same word at edge N+1 returns new data.
//  - RD_WB, MemtoReg_WB, ALU_OUT_WB copy inputs each edge (no stall/flush port).
//  - PCSrc/PC_Branch_OUT purely combinational; no registered state.
// TESTING
//  1 SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> READ_DATA_WB=0xDEADBEEF, RegWrite_WB=1.
//  2 SW 0 @0x20; SB 0xAB @0x21; LW @0x20 -> 0x0000AB00; LB @0x21 -> 0xFFFFFFAB; LBU -> 0x000000AB.
//  3 SH 0x8001 @0x32; LH @0x32 -> 0xFFFF8001; LHU -> 0x00008001.
//  4 LW @0x13 -> READ_DATA_WB=0, RegWrite_WB=0, MISALIGN_WB=1 one cycle; SW @0x12 leaves word unchanged.
//  5 Branch=1,Zero=1,PC_Branch=0x40 -> PCSrc=1, PC_Branch_OUT=0x40 same cycle; Zero=0 -> PCSrc=0.
//  6 Assert reset mid-cycle during load -> all *_WB = 0 before next edge; prior stored data retained.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage with the MEM/WB pipeline register.
// Performs byte/half/word loads and stores on a word-addressed data memory,
// resolves the branch decision for IF, and registers write-back info for WB.
module mem_wb_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RD_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Branch_MEM,
  input  logic        Zero_MEM,
  input  logic [2:0]  FUNCT3_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] PC_Branch_MEM,
  input  logic [31:0] REG_DATA2_MEM_FINAL,
  output logic        PCSrc,
  output logic [31:0] PC_Branch_OUT,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic [31:0] READ_DATA_WB,
  output logic [31:0] ALU_OUT_WB,
  output logic        MISALIGN_WB
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic [31:0]       store_lanes;
  logic [3:0]        byte_en;
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              sign_ext;
  logic              misalign;
  logic              mem_access;

  // Upper address bits beyond the array are ignored, so accesses wrap around.
  assign word_idx   = ALU_OUT_MEM[ADDR_W+1:2];
  assign lane       = ALU_OUT_MEM[1:0];
  assign rd_word    = mem[word_idx];
  assign mem_access = MemRead_MEM | MemWrite_MEM;

  assign PCSrc         = Branch_MEM & Zero_MEM;
  assign PC_Branch_OUT = PC_Branch_MEM;

  // Decode access size and signedness; unknown codes behave as full words.
  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    sign_ext = 1'b0;
    case (FUNCT3_MEM)
      3'b000: begin is_byte = 1'b1; sign_ext = 1'b1; end
      3'b001: begin is_half = 1'b1; sign_ext = 1'b1; end
      3'b100: is_byte = 1'b1;
      3'b101: is_half = 1'b1;
      default: is_word = 1'b1;
    endcase
  end

  assign misalign = (is_half & lane[0]) | (is_word & (lane != 2'b00));

  // Pick the addressed byte/half of the read word and extend it to 32 bits.
  always_comb begin
    rd_byte   = rd_word[7:0];
    load_data = rd_word;
    case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    if (is_byte) begin
      load_data = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
    end else if (is_half) begin
      load_data = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
    end
  end

  // Replicate store data across lanes and enable only the lanes being written.
  always_comb begin
    byte_en     = 4'b1111;
    store_lanes = REG_DATA2_MEM_FINAL;
    if (is_byte) begin
      byte_en     = 4'b0001 << lane;
      store_lanes = {4{REG_DATA2_MEM_FINAL[7:0]}};
    end else if (is_half) begin
      byte_en     = lane[1] ? 4'b1100 : 4'b0011;
      store_lanes = {2{REG_DATA2_MEM_FINAL[15:0]}};
    end
  end

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (MemWrite_MEM && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_lanes[8*i +: 8];
      end
    end
  end

  // MEM/WB register; a misaligned load never writes the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RD_WB        <= 5'd0;
      RegWrite_WB  <= 1'b0;
      MemtoReg_WB  <= 1'b0;
      READ_DATA_WB <= 32'd0;
      ALU_OUT_WB   <= 32'd0;
      MISALIGN_WB  <= 1'b0;
    end else begin
      RD_WB        <= RD_MEM;
      RegWrite_WB  <= RegWrite_MEM & ~(MemRead_MEM & misalign);
      MemtoReg_WB  <= MemtoReg_MEM;
      READ_DATA_WB <= (MemRead_MEM && !misalign) ? load_data : 32'd0;
      ALU_OUT_WB   <= ALU_OUT_MEM;
      MISALIGN_WB  <= mem_access & misalign;
    end
  end

endmodule
